// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types for the I2C master. Includes the controller state
//                encoding, the four quarter-bit phases, and the function that
//                computes quarter-bit length in clock cycles.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WRITE     = 4'd4,
        ST_WRITE_ACK = 4'd5,
        ST_READ      = 4'd6,
        ST_READ_ACK  = 4'd7,
        ST_STOP      = 4'd8,
        ST_DONE      = 4'd9
    } i2c_state_t;

    // A bit frame has four phases. SCL is low in PH_0 and PH_3 and high in
    // PH_1 and PH_2. SDA changes only at the PH_3 -> PH_0 boundary, which
    // falls in the middle of the SCL-low interval. SDA is sampled at the end
    // of PH_1, which is the midpoint of the SCL-high interval.
    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } i2c_phase_t;

    function automatic int unsigned qtr_cycles(input int unsigned clk_hz,
                                               input int unsigned i2c_hz);
        int unsigned q;
        q = clk_hz / (4 * i2c_hz);
        return (q == 0) ? 1 : q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tick_gen
//  Description : Quarter-bit timer. While enabled it counts QTR cycles per
//                phase and steps through PH_0..PH_3. The counter freezes while
//                hold_i is high, which implements clock stretching.
//  Ports       : clk, reset  - clock, asynchronous active-high reset
//                en_i        - run; when low, counter and phase return to 0
//                hold_i      - freeze counter (SCL released but still low)
//                tick_o      - last cycle of the current phase
//                phase_o     - current quarter phase
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned QTR = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       hold_i,
    output logic       tick_o,
    output i2c_phase_t phase_o
);

    localparam int unsigned   CW     = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(QTR - 1);

    logic [CW-1:0] cnt_q;
    i2c_phase_t    phase_q;

    assign tick_o  = en_i && !hold_i && (cnt_q == C_LAST);
    assign phase_o = phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= PH_0;
        end else if (!en_i) begin
            cnt_q   <= '0;
            phase_q <= PH_0;
        end else if (!hold_i) begin
            if (cnt_q == C_LAST) begin
                cnt_q   <= '0;
                phase_q <= i2c_phase_t'(phase_q + 2'd1);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master
//  Description : Single-master I2C controller with 7-bit addressing. Each
//                start request runs one write or one read of up to
//                MAX_BYTES_PER_TRANSACTION data bytes. SCL and SDA are
//                open-drain.
//  Ports       : clk, reset              - clock, asynchronous active-high reset
//                transaction_start       - 1-cycle request, accepted in IDLE only
//                rd_nwr, slave_addr      - direction (1 = read) and target address
//                din                     - write bytes; din[0] is sent first
//                transaction_bytes_num   - data byte count, clamped to MAX
//                scl_pin, sda_pin        - open-drain bus pins
//                dout                    - read bytes; dout[0] is received first
//                transaction_done        - 1-cycle pulse at the end of each transfer
//                error                   - slave NACK seen in the last transfer
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_master
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_BYTES_PER_TRANSACTION = 3,
    parameter int unsigned CLK_FREQ_HZ               = 125_000_000,
    parameter int unsigned I2C_FREQ_HZ               = 100_000
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      transaction_start,
    input  logic                                      rd_nwr,
    input  logic [6:0]                                slave_addr,
    input  logic [0:MAX_BYTES_PER_TRANSACTION-1][7:0] din,
    input  logic [$clog2(MAX_BYTES_PER_TRANSACTION+1)-1:0] transaction_bytes_num,
    inout  wire                                       scl_pin,
    inout  wire                                       sda_pin,
    output logic [0:MAX_BYTES_PER_TRANSACTION-1][7:0] dout,
    output logic                                      transaction_done,
    output logic                                      error
);

    localparam int unsigned   N     = MAX_BYTES_PER_TRANSACTION;
    localparam int unsigned   CW    = $clog2(N + 1);
    localparam logic [CW-1:0] C_N   = CW'(N);
    localparam int unsigned   QTR   = qtr_cycles(CLK_FREQ_HZ, I2C_FREQ_HZ);

    i2c_state_t            state_q,  state_d;
    logic                  rd_q,     rd_d;
    logic [6:0]            addr_q,   addr_d;
    logic [0:N-1][7:0]     din_q,    din_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [CW-1:0]         idx_q,    idx_d;
    logic [2:0]            bit_q,    bit_d;
    logic [7:0]            shift_q,  shift_d;
    logic                  samp_q,   samp_d;
    logic [0:N-1][7:0]     dout_q,   dout_d;
    logic                  err_q,    err_d;
    logic                  done_q,   done_d;

    logic                  tick;
    i2c_phase_t            phase;
    logic                  scl_drive_low;
    logic                  sda_drive_low;
    logic [CW-1:0]         idx_inc;
    logic                  last_byte;
    logic                  frame_end;
    logic                  sample;

    assign idx_inc   = idx_q + 1'b1;
    assign last_byte = (idx_inc == cnt_q);
    assign frame_end = tick && (phase == PH_3);
    assign sample    = tick && (phase == PH_1);

    // The timer is frozen while SCL is released but a slave still holds it low.
    i2c_tick_gen #(.QTR(QTR)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q != ST_IDLE),
        .hold_i  (!scl_drive_low && (scl_pin == 1'b0)),
        .tick_o  (tick),
        .phase_o (phase)
    );

    // Pin waveforms. These depend only on registered state, so the pins
    // release as soon as reset asserts.
    always_comb begin
        scl_drive_low = 1'b0;
        sda_drive_low = 1'b0;
        case (state_q)
            ST_START: begin
                sda_drive_low = (phase != PH_0);   // SDA falls while SCL is high
                scl_drive_low = (phase == PH_3);
            end
            ST_ADDR, ST_WRITE: begin
                scl_drive_low = (phase == PH_0) || (phase == PH_3);
                sda_drive_low = !shift_q[7];
            end
            ST_ADDR_ACK, ST_WRITE_ACK, ST_READ: begin
                scl_drive_low = (phase == PH_0) || (phase == PH_3);
            end
            ST_READ_ACK: begin
                scl_drive_low = (phase == PH_0) || (phase == PH_3);
                sda_drive_low = !last_byte;       // ACK all bytes except the last
            end
            ST_STOP: begin
                scl_drive_low = (phase == PH_0);
                sda_drive_low = (phase == PH_0) || (phase == PH_1); // SDA rises in PH_2
            end
            default: ;
        endcase
    end

    assign scl_pin = scl_drive_low ? 1'b0 : 1'bz;
    assign sda_pin = sda_drive_low ? 1'b0 : 1'bz;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        din_d   = din_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        dout_d  = dout_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (sample) begin
            samp_d = sda_pin;
            if (state_q == ST_READ) begin
                shift_d = {shift_q[6:0], sda_pin};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (transaction_start) begin
                    rd_d    = rd_nwr;
                    addr_d  = slave_addr;
                    din_d   = din;
                    cnt_d   = (transaction_bytes_num > C_N) ? C_N : transaction_bytes_num;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (frame_end) begin
                    shift_d = {addr_q, rd_q};
                    bit_d   = 3'd7;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR, ST_WRITE: begin
                if (frame_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WRITE_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q - 3'd1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (frame_end) begin
                    idx_d = '0;
                    bit_d = 3'd7;
                    if (samp_q) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (cnt_q == '0) begin
                        state_d = ST_STOP;
                    end else if (rd_q) begin
                        state_d = ST_READ;
                    end else begin
                        shift_d = din_q[0];
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE_ACK: begin
                if (frame_end) begin
                    if (samp_q) begin
                        err_d   = 1'b1;
                        state_d = ST_STOP;
                    end else if (last_byte) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_inc;
                        shift_d = din_q[idx_inc];
                        bit_d   = 3'd7;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (frame_end) begin
                    if (bit_q == 3'd0) begin
                        // The final bit was shifted in at PH_1 of this frame.
                        dout_d[idx_q] = shift_q;
                        state_d       = ST_READ_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            ST_READ_ACK: begin
                if (frame_end) begin
                    if (last_byte) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_inc;
                        bit_d   = 3'd7;
                        state_d = ST_READ;
                    end
                end
            end
            ST_STOP: begin
                if (frame_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                // A full frame with both lines released guarantees bus idle time.
                if (frame_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            samp_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            samp_q  <= samp_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign dout             = dout_q;
    assign error            = err_q;
    assign transaction_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master
//  Description : Directed testbench for i2c_master. It contains a behavioural
//                I2C slave at address 0x48 with pullups, monitors for START,
//                STOP and done pulses, and hand-computed expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_master;

    localparam int unsigned C_N       = 3;
    localparam logic [6:0]  C_SL_ADDR = 7'h48;

    logic              clk;
    logic              reset;
    logic              transaction_start;
    logic              rd_nwr;
    logic [6:0]        slave_addr;
    logic [0:C_N-1][7:0] din;
    logic [1:0]        transaction_bytes_num;
    wire               scl_bus;
    wire               sda_bus;
    logic [0:C_N-1][7:0] dout;
    logic              transaction_done;
    logic              error;

    // Slave side of the bus
    logic              slave_en;
    logic              sl_sda_drv;
    logic              sl_scl_drv;
    logic [7:0]        sl_data [0:C_N-1];
    int                sl_nbytes;
    logic              stretch_en;
    logic [7:0]        rx_q [$];
    logic              mack_q [$];

    int                done_cnt;
    int                start_cnt;
    int                stop_cnt;
    int                n_vec;
    int                n_miss;

    assign sda_bus = (slave_en && sl_sda_drv) ? 1'b0 : 1'bz;
    assign scl_bus = (slave_en && sl_scl_drv) ? 1'b0 : 1'bz;
    pullup (sda_bus);
    pullup (scl_bus);

    i2c_master #(
        .MAX_BYTES_PER_TRANSACTION (C_N),
        .CLK_FREQ_HZ               (4_000_000),
        .I2C_FREQ_HZ               (100_000)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .transaction_start     (transaction_start),
        .rd_nwr                (rd_nwr),
        .slave_addr            (slave_addr),
        .din                   (din),
        .transaction_bytes_num (transaction_bytes_num),
        .scl_pin               (scl_bus),
        .sda_pin               (sda_bus),
        .dout                  (dout),
        .transaction_done      (transaction_done),
        .error                 (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (transaction_done === 1'b1) done_cnt <= done_cnt + 1;
    always @(negedge sda_bus) if (scl_bus === 1'b1) start_cnt <= start_cnt + 1;
    always @(posedge sda_bus) if (scl_bus === 1'b1) stop_cnt  <= stop_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    task automatic sl_get_byte(output logic [7:0] b);
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            @(posedge scl_bus);
            b[i] = sda_bus;
            if (i == 4 && stretch_en) begin
                stretch_en = 1'b0;
                @(negedge scl_bus);
                #1 sl_scl_drv = 1'b1;
                repeat (500) @(posedge clk);
                sl_scl_drv = 1'b0;
            end
        end
    endtask

    task automatic sl_ack();
        @(negedge scl_bus);
        #1 sl_sda_drv = 1'b1;
        @(negedge scl_bus);
        #1 sl_sda_drv = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        sl_sda_drv = 1'b0;
        sl_scl_drv = 1'b0;
        forever begin
            @(negedge sda_bus);
            if (scl_bus !== 1'b1) continue;
            sl_get_byte(b);
            rx_q.push_back(b);
            if (b[7:1] != C_SL_ADDR) continue;
            if (!b[0]) begin
                sl_ack();
                for (int k = 0; k < sl_nbytes; k++) begin
                    sl_get_byte(b);
                    rx_q.push_back(b);
                    sl_ack();
                end
            end else begin
                @(negedge scl_bus);
                #1 sl_sda_drv = 1'b1;
                for (int k = 0; k < sl_nbytes; k++) begin
                    for (int i = 7; i >= 0; i--) begin
                        @(negedge scl_bus);
                        #1 sl_sda_drv = !sl_data[k][i];
                    end
                    @(negedge scl_bus);
                    #1 sl_sda_drv = 1'b0;
                    @(posedge scl_bus);
                    mack_q.push_back(sda_bus);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] rx_word();
        logic [31:0] w;
        w = '0;
        foreach (rx_q[i]) w = {w[23:0], rx_q[i]};
        return w;
    endfunction

    task automatic run_txn(input logic rd, input logic [6:0] a, input logic [0:C_N-1][7:0] d,
                           input logic [1:0] n, input logic poke, output int cycles);
        rx_q.delete();
        mack_q.delete();
        @(negedge clk);
        rd_nwr                = rd;
        slave_addr            = a;
        din                   = d;
        transaction_bytes_num = n;
        transaction_start     = 1'b1;
        @(negedge clk);
        transaction_start = 1'b0;
        cycles = 0;
        while (transaction_done !== 1'b1 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            transaction_start = 1'b0;
            if (poke && cycles == 100) begin
                // Request while busy: must be ignored, as must these new values.
                transaction_start     = 1'b1;
                rd_nwr                = 1'b1;
                slave_addr            = 7'h49;
                transaction_bytes_num = 2'd2;
            end
        end
        transaction_start = 1'b0;
        check("txn_timeout", {31'd0, transaction_done}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0, s0, p0, cyc, base;
        n_vec = 0; n_miss = 0;
        done_cnt = 0; start_cnt = 0; stop_cnt = 0;
        slave_en = 1'b1; stretch_en = 1'b0; sl_nbytes = 0;
        for (int i = 0; i < C_N; i++) sl_data[i] = '0;
        reset = 1'b1; transaction_start = 1'b0; rd_nwr = 1'b0;
        slave_addr = '0; din = '0; transaction_bytes_num = '0;
        repeat (4) @(negedge clk);
        check("rst_scl",   {31'd0, scl_bus}, 32'd1);
        check("rst_sda",   {31'd0, sda_bus}, 32'd1);
        check("rst_dout",  {8'd0, dout}, 32'd0);
        check("rst_done",  {31'd0, transaction_done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 3-byte write
        d0 = done_cnt; s0 = start_cnt; p0 = stop_cnt; sl_nbytes = 3;
        run_txn(1'b0, 7'h48, {8'h01, 8'h42, 8'h83}, 2'd3, 1'b0, cyc);
        check("wr_nbytes", rx_q.size(), 4);
        check("wr_bytes",  rx_word(), 32'h9001_4283);
        check("wr_error",  {31'd0, error}, 32'd0);
        check("wr_done",   done_cnt - d0, 1);
        check("wr_start",  start_cnt - s0, 1);
        check("wr_stop",   stop_cnt - p0, 1);

        // 2-byte read
        d0 = done_cnt; p0 = stop_cnt; sl_nbytes = 2;
        sl_data[0] = 8'h12; sl_data[1] = 8'h34;
        run_txn(1'b1, 7'h48, '0, 2'd2, 1'b0, cyc);
        check("rd_addr",  rx_word(), 32'h0000_0091);
        check("rd_mack",  {30'd0, (mack_q.size() == 2) ? {mack_q[0], mack_q[1]} : 2'b11}, 32'd1);
        check("rd_dout",  {8'd0, dout}, 32'h0012_3400);
        check("rd_error", {31'd0, error}, 32'd0);
        check("rd_done",  done_cnt - d0, 1);
        check("rd_stop",  stop_cnt - p0, 1);

        // Address NACK; dout must be left untouched
        d0 = done_cnt; p0 = stop_cnt;
        run_txn(1'b1, 7'h49, '0, 2'd2, 1'b0, cyc);
        check("nack_error", {31'd0, error}, 32'd1);
        check("nack_bytes", rx_word(), 32'h0000_0093);
        check("nack_dout",  {8'd0, dout}, 32'h0012_3400);
        check("nack_done",  done_cnt - d0, 1);
        check("nack_stop",  stop_cnt - p0, 1);

        // Good write with a start request while busy; error must clear
        d0 = done_cnt; sl_nbytes = 1;
        run_txn(1'b0, 7'h48, {8'h5A, 8'h00, 8'h00}, 2'd1, 1'b1, cyc);
        check("busy_error", {31'd0, error}, 32'd0);
        check("busy_bytes", rx_word(), 32'h0000_905A);
        check("busy_done",  done_cnt - d0, 1);

        // Count 0: address-only frame followed by STOP
        p0 = stop_cnt; sl_nbytes = 0;
        run_txn(1'b0, 7'h48, {8'hFF, 8'hFF, 8'hFF}, 2'd0, 1'b0, cyc);
        check("cnt0_bytes", rx_word(), 32'h0000_0090);
        check("cnt0_error", {31'd0, error}, 32'd0);
        check("cnt0_stop",  stop_cnt - p0, 1);

        // Clock stretching: the transfer takes about 480 cycles longer
        // (a 500-cycle hold minus the 20 cycles SCL was already low).
        sl_nbytes = 1;
        run_txn(1'b0, 7'h48, {8'hA5, 8'h00, 8'h00}, 2'd1, 1'b0, base);
        stretch_en = 1'b1;
        run_txn(1'b0, 7'h48, {8'hA5, 8'h00, 8'h00}, 2'd1, 1'b0, cyc);
        check("str_bytes", rx_word(), 32'h0000_90A5);
        check("str_error", {31'd0, error}, 32'd0);
        check("str_delay", {31'd0, (cyc - base >= 470) && (cyc - base <= 490)}, 32'd1);

        // Reset in the middle of a read
        d0 = done_cnt; sl_nbytes = 2;
        sl_data[0] = 8'h56; sl_data[1] = 8'h78;
        @(negedge clk);
        rd_nwr = 1'b1; slave_addr = 7'h48; transaction_bytes_num = 2'd2;
        transaction_start = 1'b1;
        @(negedge clk);
        transaction_start = 1'b0;
        repeat (800) @(negedge clk);
        slave_en = 1'b0;
        reset    = 1'b1;
        #1;
        check("mrst_scl",  {31'd0, scl_bus}, 32'd1);
        check("mrst_sda",  {31'd0, sda_bus}, 32'd1);
        check("mrst_dout", {8'd0, dout}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("mrst_nodone", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
